barramento_arbitrado: RTL and testbench

- Parametrised successor to the six-port tristate bus.
- Connects N_PORTAS units (pilha, memoria, temp1, temp2, ula, uc, …) over a registered, arbitrated, multiplexed bus. There are no internal tristates.
- Any number of units may request a write in the same cycle. An arbiter grants exactly one per cycle, using either fixed-priority or round-robin mode.
- The granted word is registered and broadcast next cycle to every port requesting a read. Collisions are counted for debug.

---
 rtl/barramento_arbitrado.sv | 100 ++++++++++
 tb/tb_barramento_arbitrado.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/barramento_arbitrado.sv
// Registered, arbitrated bus shared by N_PORTAS units: one writer granted per cycle,
// word broadcast one clock later to every reading port.

module barramento_porta #(
  parameter int LARGURA = 16
) (
  input  logic               ocupado,
  input  logic               req_r,
  input  logic [LARGURA-1:0] barramento,
  output logic               valido,
  output logic [LARGURA-1:0] dado
);
  assign valido = ocupado & req_r;
  assign dado   = valido ? barramento : '0;
endmodule

module barramento_arbitrado #(
  parameter int LARGURA   = 16,
  parameter int N_PORTAS  = 6,
  parameter int MODO_ARB  = 0,
  parameter int LARG_CONT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_PORTAS-1:0]           req_w,
  input  logic [N_PORTAS*LARGURA-1:0]   dado_w,
  input  logic [N_PORTAS-1:0]           req_r,
  output logic [N_PORTAS-1:0]           gnt_w,
  output logic [N_PORTAS*LARGURA-1:0]   dado_r,
  output logic [N_PORTAS-1:0]           valido_r,
  output logic                          ocupado,
  output logic [LARG_CONT-1:0]          colisoes
);
  localparam int IW     = $clog2(N_PORTAS);
  localparam int STAGES = 1;

  logic [N_PORTAS-1:0][LARGURA-1:0] dw, dr;
  logic [IW-1:0]                    ult_gnt, idx;
  logic                             achou;
  logic [LARGURA-1:0]               barramento_reg;
  logic [STAGES:0]                  vld_pipe;

  assign dw = dado_w;

  // Priority search; round robin starts just after the last granted port and wraps.
  always_comb begin
    idx   = '0;
    achou = 1'b0;
    gnt_w = '0;
    if (MODO_ARB == 0) begin
      for (int i = 0; i < N_PORTAS; i++)
        if (!achou && req_w[i]) begin
          achou = 1'b1;
          idx   = IW'(i);
        end
    end else begin
      for (int k = 1; k <= N_PORTAS; k++) begin
        int j;
        j = (int'(ult_gnt) + k) % N_PORTAS;
        if (!achou && req_w[j]) begin
          achou = 1'b1;
          idx   = IW'(j);
        end
      end
    end
    if (achou) gnt_w[idx] = 1'b1;
  end

  assign vld_pipe[0] = achou;
  assign ocupado     = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      barramento_reg       <= '0;
      vld_pipe[STAGES:1]   <= '0;
      colisoes             <= '0;
      ult_gnt              <= IW'(N_PORTAS - 1);
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (achou) begin
        barramento_reg <= dw[idx];
        ult_gnt        <= idx;
      end
      if ($countones(req_w) >= 2 && colisoes != {LARG_CONT{1'b1}})
        colisoes <= colisoes + 1'b1;
    end
  end

  for (genvar i = 0; i < N_PORTAS; i++) begin : g_porta
    barramento_porta #(.LARGURA(LARGURA)) u_porta (
      .ocupado    (ocupado),
      .req_r      (req_r[i]),
      .barramento (barramento_reg),
      .valido     (valido_r[i]),
      .dado       (dr[i])
    );
  end

  assign dado_r = dr;
endmodule

// File: tb/tb_barramento_arbitrado.sv
// Drives three bus variants (fixed priority, round robin, 4-bit counter) from shared
// inputs and compares each against a behavioural model every cycle.
module tb_barramento_arbitrado;
  localparam int N = 6, W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [N-1:0]   req_w, req_r;
  logic [N*W-1:0] dado_w;
  logic [N-1:0]   gnt [3];
  logic [N*W-1:0] dr  [3];
  logic [N-1:0]   vr  [3];
  logic           oc  [3];
  logic [7:0]     col0, col1;
  logic [3:0]     col2;

  barramento_arbitrado #(.LARGURA(W), .N_PORTAS(N), .MODO_ARB(0), .LARG_CONT(8)) u0 (
    .clk(clk), .rst(rst), .req_w(req_w), .dado_w(dado_w), .req_r(req_r),
    .gnt_w(gnt[0]), .dado_r(dr[0]), .valido_r(vr[0]), .ocupado(oc[0]), .colisoes(col0));
  barramento_arbitrado #(.LARGURA(W), .N_PORTAS(N), .MODO_ARB(1), .LARG_CONT(8)) u1 (
    .clk(clk), .rst(rst), .req_w(req_w), .dado_w(dado_w), .req_r(req_r),
    .gnt_w(gnt[1]), .dado_r(dr[1]), .valido_r(vr[1]), .ocupado(oc[1]), .colisoes(col1));
  barramento_arbitrado #(.LARGURA(W), .N_PORTAS(N), .MODO_ARB(0), .LARG_CONT(4)) u2 (
    .clk(clk), .rst(rst), .req_w(req_w), .dado_w(dado_w), .req_r(req_r),
    .gnt_w(gnt[2]), .dado_r(dr[2]), .valido_r(vr[2]), .ocupado(oc[2]), .colisoes(col2));

  // Reference model state per variant
  logic [W-1:0] m_bus [3];
  logic         m_oc  [3];
  int           m_col [3];
  int           m_ptr [3];
  int           m_max [3] = '{255, 255, 15};
  int           mode  [3] = '{0, 1, 0};

  int checks = 0, failures = 0;

  function automatic int arb(int m, logic [N-1:0] r);
    if (mode[m] == 0) begin
      for (int i = 0; i < N; i++) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (r[(m_ptr[m] + k) % N]) return (m_ptr[m] + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model(input int m);
    m_bus[m] = '0; m_oc[m] = 1'b0; m_col[m] = 0; m_ptr[m] = N - 1;
  endtask

  function automatic logic [127:0] colv(int m);
    case (m)
      0:       return 128'(col0);
      1:       return 128'(col1);
      default: return 128'(col2);
    endcase
  endfunction

  task automatic step(input logic r, input logic [N-1:0] rw, input logic [N-1:0] rr,
                      input logic [N*W-1:0] dw);
    @(negedge clk);
    rst = r; req_w = rw; req_r = rr; dado_w = dw;
    #1;
    for (int m = 0; m < 3; m++) begin
      int g;
      logic [N-1:0]   eg, ev;
      logic [N*W-1:0] ed;
      g  = arb(m, rw);
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      for (int i = 0; i < N; i++) begin
        ev[i] = m_oc[m] & rr[i];
        ed[i*W +: W] = ev[i] ? m_bus[m] : '0;
      end
      chk($sformatf("gnt_w[u%0d]", m),    128'(gnt[m]), 128'(eg));
      chk($sformatf("valido_r[u%0d]", m), 128'(vr[m]),  128'(ev));
      chk($sformatf("dado_r[u%0d]", m),   128'(dr[m]),  128'(ed));
      chk($sformatf("ocupado[u%0d]", m),  128'(oc[m]),  128'(m_oc[m]));
      chk($sformatf("colisoes[u%0d]", m), colv(m),      128'(m_col[m]));
      // state after the coming rising edge
      if (r) reset_model(m);
      else begin
        if (g >= 0) begin
          m_bus[m] = dw[g*W +: W]; m_oc[m] = 1'b1; m_ptr[m] = g;
        end else m_oc[m] = 1'b0;
        if ($countones(rw) >= 2 && m_col[m] < m_max[m]) m_col[m]++;
      end
    end
  endtask

  initial begin
    logic [N*W-1:0] dw;
    rst = 1'b1; req_w = '0; req_r = '0; dado_w = '0;
    @(posedge clk);
    for (int m = 0; m < 3; m++) reset_model(m);

    // reset state, then idle
    step(1'b1, '0, '0, '0);
    for (int c = 0; c < 3; c++) step(1'b0, '0, '0, '0);
    chk("idle_gnt", 128'(gnt[0]), 128'(0));
    chk("idle_col", 128'(col0), 128'(0));

    // single write from port 2, read by ports 0 and 5
    dw = '0; dw[2*W +: W] = 16'hA5A5;
    step(1'b0, 6'b000100, '0, dw);
    chk("single_gnt", 128'(gnt[0]), 128'(6'b000100));
    step(1'b0, '0, 6'b100001, '0);
    chk("single_rd0", 128'(dr[0][0 +: W]),   128'(16'hA5A5));
    chk("single_rd5", 128'(dr[0][5*W +: W]), 128'(16'hA5A5));
    chk("single_vld", 128'(vr[0]), 128'(6'b100001));
    chk("single_oc",  128'(oc[0]), 128'(1));
    step(1'b0, '0, '0, '0);
    chk("single_oc_drop", 128'(oc[0]), 128'(0));

    // fixed-priority collision among ports 1, 3, 4
    dw = '0; dw[1*W +: W] = 16'h0011; dw[3*W +: W] = 16'h0033; dw[4*W +: W] = 16'h0044;
    step(1'b0, 6'b011010, 6'b000001, dw);
    chk("fp_gnt1", 128'(gnt[0]), 128'(6'b000010));
    step(1'b0, 6'b011000, 6'b000001, dw);
    chk("fp_gnt3", 128'(gnt[0]), 128'(6'b001000));
    chk("fp_rd11", 128'(dr[0][0 +: W]), 128'(16'h0011));
    step(1'b0, 6'b010000, 6'b000001, dw);
    chk("fp_gnt4", 128'(gnt[0]), 128'(6'b010000));
    chk("fp_rd33", 128'(dr[0][0 +: W]), 128'(16'h0033));
    step(1'b0, '0, 6'b000001, '0);
    chk("fp_rd44", 128'(dr[0][0 +: W]), 128'(16'h0044));
    chk("fp_col",  128'(col0), 128'(2));

    // round robin, all ports requesting for 8 cycles
    step(1'b1, '0, '0, '0);
    dw = {6{16'h1234}};
    for (int k = 0; k < 8; k++) begin
      logic [N-1:0] e;
      e = '0; e[k % N] = 1'b1;
      step(1'b0, '1, '0, dw);
      chk("rr_gnt", 128'(gnt[1]), 128'(e));
    end
    step(1'b0, '0, '0, '0);
    chk("rr_col", 128'(col1), 128'(8));

    // counter saturation
    step(1'b1, '0, '0, '0);
    for (int k = 0; k < 20; k++) step(1'b0, 6'b000011, '0, dw);
    step(1'b0, '0, '0, '0);
    chk("sat_col4", 128'(col2), 128'(15));
    chk("sat_col8", 128'(col0), 128'(20));

    // reset mid-stream
    dw = '0; dw[3*W +: W] = 16'hBEEF; dw[2*W +: W] = 16'h5555;
    step(1'b0, 6'b001000, '0, dw);
    step(1'b1, 6'b000100, '1, dw);
    chk("mid_rd_beef", 128'(dr[0][0 +: W]), 128'(16'hBEEF));
    chk("mid_gnt_in_rst", 128'(gnt[0]), 128'(6'b000100));
    step(1'b0, '1, '1, dw);
    chk("mid_oc",  128'(oc[0]), 128'(0));
    chk("mid_vld", 128'(vr[0]), 128'(0));
    chk("mid_dr",  128'(dr[0]), 128'(0));
    chk("mid_rr0", 128'(gnt[1]), 128'(6'b000001));

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      logic r;
      logic [N-1:0] rw, rr;
      r  = ($urandom_range(31) == 0);
      rw = N'($urandom);
      if ($urandom_range(3) == 0) rw = '0;
      rr = N'($urandom);
      dw = {$urandom, $urandom, $urandom};
      step(r, rw, rr, dw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
